// File: rtl/sbqm_pkg.sv
// Shared types and defaults for the photocell conditioner slice.
package sbqm_pkg;

  localparam int unsigned DEB_CYCLES_DEF   = 4;
  localparam int unsigned STUCK_CYCLES_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_ACTIVE,
    ST_RELEASE_WAIT,
    ST_FAULT
  } chan_state_e;

endpackage

// File: rtl/sbqm_sensor_conditioner_if.sv
// Raw photocell inputs and conditioned outputs of the queue sensor front-end.
interface sbqm_sensor_conditioner_if;

  logic raw_front;
  logic raw_back;
  logic sens_front;
  logic sens_back;
  logic front_evt;
  logic back_evt;
  logic both_evt;
  logic stuck_front;
  logic stuck_back;

  modport master (
    output raw_front, raw_back,
    input  sens_front, sens_back, front_evt, back_evt, both_evt,
           stuck_front, stuck_back
  );

  modport slave (
    input  raw_front, raw_back,
    output sens_front, sens_back, front_evt, back_evt, both_evt,
           stuck_front, stuck_back
  );

endinterface

// File: rtl/sbqm_sensor_channel.sv
// One photocell channel: 2-flop synchroniser, debounce FSM, saturating counter.
// Optional stuck-beam detection is enabled by defining STUCK_DET_EN.
module sbqm_sensor_channel
  import sbqm_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF,
  parameter int unsigned CNT_W        = $clog2(STUCK_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_sens,
  output logic o_evt,
  output logic o_evt_set,
  output logic o_stuck
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES);

  logic             r_s1;
  logic             r_s2;
  chan_state_e      r_state;
  chan_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_sens;
  logic             w_sens_nxt;
  logic             r_evt;
  logic             w_evt_set;

`ifdef STUCK_DET_EN
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES);
  logic r_stuck;
  logic w_stuck_nxt;
`endif

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  // Transitions fire on the edge where the incremented count reaches the
  // threshold, so DEB_CYCLES consecutive low samples of s2 accept a press.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sens_nxt  = r_sens;
    w_evt_set   = 1'b0;
`ifdef STUCK_DET_EN
    w_stuck_nxt = r_stuck;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!r_s2) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (r_s2) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == DEB_LAST) begin
          w_state_nxt = ST_ACTIVE;
          w_cnt_nxt   = '0;
          w_sens_nxt  = 1'b0;
          w_evt_set   = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_ACTIVE: begin
        if (r_s2) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
`ifdef STUCK_DET_EN
          if (w_cnt_inc == STUCK_LAST) begin
            w_state_nxt = ST_FAULT;
            w_cnt_nxt   = '0;
            w_sens_nxt  = 1'b1;
            w_stuck_nxt = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
`else
          w_cnt_nxt = '0;
`endif
        end
      end
      ST_RELEASE_WAIT: begin
        if (!r_s2) begin
          w_state_nxt = ST_ACTIVE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == DEB_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_sens_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
`ifdef STUCK_DET_EN
      ST_FAULT: begin
        if (!r_s2) begin
          w_cnt_nxt = '0;
        end else if (w_cnt_inc == DEB_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_stuck_nxt = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_sens_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sens  <= 1'b1;
      r_evt   <= 1'b0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sens  <= w_sens_nxt;
      r_evt   <= w_evt_set;
    end
  end

`ifdef STUCK_DET_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stuck <= 1'b0;
    end else begin
      r_stuck <= w_stuck_nxt;
    end
  end
  assign o_stuck = r_stuck;
`else
  assign o_stuck = 1'b0;
`endif

  assign o_sens    = r_sens;
  assign o_evt     = r_evt;
  assign o_evt_set = w_evt_set;

endmodule

// File: rtl/sbqm_sensor_conditioner.sv
// Queue sensor front-end: two independent debounced channels plus a coincidence strobe.
// Optional stuck-beam detection is enabled by defining STUCK_DET_EN.
module sbqm_sensor_conditioner
  import sbqm_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF,
  parameter int unsigned CNT_W        = $clog2(STUCK_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  sbqm_sensor_conditioner_if.slave   bus
);

  logic w_front_set;
  logic w_back_set;
  logic r_both_evt;

  sbqm_sensor_channel #(
    .DEB_CYCLES   (DEB_CYCLES),
    .STUCK_CYCLES (STUCK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_front (
    .clk       (clk),
    .rst       (rst),
    .i_raw     (bus.raw_front),
    .o_sens    (bus.sens_front),
    .o_evt     (bus.front_evt),
    .o_evt_set (w_front_set),
    .o_stuck   (bus.stuck_front)
  );

  sbqm_sensor_channel #(
    .DEB_CYCLES   (DEB_CYCLES),
    .STUCK_CYCLES (STUCK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_back (
    .clk       (clk),
    .rst       (rst),
    .i_raw     (bus.raw_back),
    .o_sens    (bus.sens_back),
    .o_evt     (bus.back_evt),
    .o_evt_set (w_back_set),
    .o_stuck   (bus.stuck_back)
  );

  // Built from the pre-register strobe conditions so it lines up with both strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_both_evt <= 1'b0;
    end else begin
      r_both_evt <= w_front_set & w_back_set;
    end
  end

  assign bus.both_evt = r_both_evt;

endmodule

// File: tb/tb_sbqm_sensor_conditioner.sv
// Directed bench for sbqm_sensor_conditioner (DEB_CYCLES=4, STUCK_CYCLES=16).
module tb_sbqm_sensor_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned STK = 16;
  // Output vector order: {sens_front, sens_back, front_evt, back_evt, both_evt, stuck_front, stuck_back}
  localparam logic [6:0] O_IDLE = 7'b1100000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sbqm_sensor_conditioner_if bus();

  sbqm_sensor_conditioner #(
    .DEB_CYCLES   (DEB),
    .STUCK_CYCLES (STK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst_n;
    logic       rf;
    logic       rb;
    logic [6:0] e;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   fe_cnt = 0;
  int   be_cnt = 0;
  logic prev_fe = 1'b0;
  logic prev_be = 1'b0;

  function automatic logic [6:0] outs();
    return {bus.sens_front, bus.sens_back, bus.front_evt, bus.back_evt,
            bus.both_evt, bus.stuck_front, bus.stuck_back};
  endfunction

  function automatic void add_n(int n, logic r, logic f, logic b, logic [6:0] e);
    vec_t v;
    v.rst_n = r;
    v.rf    = f;
    v.rb    = b;
    v.e     = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.front_evt === 1'b1) fe_cnt++;
    if (bus.back_evt === 1'b1) be_cnt++;
    if (bus.front_evt === 1'b1 && prev_fe) begin
      errors++;
      $display("FAIL front_evt_twice: got 1 on consecutive cycles expected single pulse");
    end
    if (bus.back_evt === 1'b1 && prev_be) begin
      errors++;
      $display("FAIL back_evt_twice: got 1 on consecutive cycles expected single pulse");
    end
    if (bus.both_evt === 1'b1 && !(bus.front_evt === 1'b1 && bus.back_evt === 1'b1)) begin
      errors++;
      $display("FAIL both_evt_align: got both=1 with front=%b back=%b", bus.front_evt, bus.back_evt);
    end
    prev_fe = (bus.front_evt === 1'b1);
    prev_be = (bus.back_evt === 1'b1);
  endtask

  initial begin
    int fe0;
    int be0;
    int first;
    int low_cnt;

    rst = 1'b0;
    bus.raw_front = 1'b0;
    bus.raw_back  = 1'b0;

    // Reset with raw low, then a held front press and its release
    add_n(2, 1'b0, 1'b0, 1'b0, O_IDLE);
    add_n(5, 1'b1, 1'b0, 1'b1, O_IDLE);
    add_n(1, 1'b1, 1'b0, 1'b1, 7'b0110000);
    add_n(1, 1'b1, 1'b0, 1'b1, 7'b0100000);
    add_n(5, 1'b1, 1'b1, 1'b1, 7'b0100000);
    add_n(2, 1'b1, 1'b1, 1'b1, O_IDLE);
    // Simultaneous fall on both channels
    add_n(5, 1'b1, 1'b0, 1'b0, O_IDLE);
    add_n(1, 1'b1, 1'b0, 1'b0, 7'b0011100);
    add_n(1, 1'b1, 1'b0, 1'b0, 7'b0000000);
    add_n(5, 1'b1, 1'b1, 1'b1, 7'b0000000);
    add_n(2, 1'b1, 1'b1, 1'b1, O_IDLE);
    // 3-cycle pulse is rejected
    add_n(3, 1'b1, 1'b0, 1'b1, O_IDLE);
    add_n(6, 1'b1, 1'b1, 1'b1, O_IDLE);
    // 4-cycle pulse is the minimum accepted
    add_n(4, 1'b1, 1'b0, 1'b1, O_IDLE);
    add_n(1, 1'b1, 1'b1, 1'b1, O_IDLE);
    add_n(1, 1'b1, 1'b1, 1'b1, 7'b0110000);
    add_n(3, 1'b1, 1'b1, 1'b1, 7'b0100000);
    add_n(2, 1'b1, 1'b1, 1'b1, O_IDLE);
    // Reset mid-debounce discards the pending press
    add_n(4, 1'b1, 1'b0, 1'b1, O_IDLE);
    add_n(1, 1'b0, 1'b0, 1'b1, O_IDLE);
    add_n(8, 1'b1, 1'b1, 1'b1, O_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      rst           = vecs[i].rst_n;
      bus.raw_front = vecs[i].rf;
      bus.raw_back  = vecs[i].rb;
      tick();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].e));
    end

    // Chatter on raw_back, then a stable hold
    be0 = be_cnt;
    for (int i = 0; i < 20; i++) begin
      bus.raw_back = (i % 2 == 1);
      tick();
    end
    check("chatter_no_evt", 32'(be_cnt - be0), 32'd0);
    check("chatter_sens_idle", 32'(bus.sens_back), 32'd1);
    bus.raw_back = 1'b0;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.back_evt === 1'b1 && first == 0) first = k;
    end
    check("chatter_evt_latency", 32'(first), 32'd6);
    check("chatter_evt_count", 32'(be_cnt - be0), 32'd1);
    bus.raw_back = 1'b1;
    repeat (8) tick();
    check("chatter_release", 32'(outs()), 32'(O_IDLE));

    // 8 entries then 8 exits, 6 low / 6 high each
    fe0 = fe_cnt;
    be0 = be_cnt;
    low_cnt = 0;
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 12; c++) begin
        bus.raw_front = (c >= 6);
        tick();
        if (bus.sens_front === 1'b0) low_cnt++;
      end
    end
    check("entries_count", 32'(fe_cnt - fe0), 32'd8);
    check("entries_low_cycles", 32'(low_cnt), 32'd48);
    low_cnt = 0;
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 12; c++) begin
        bus.raw_back = (c >= 6);
        tick();
        if (bus.sens_back === 1'b0) low_cnt++;
      end
    end
    check("exits_count", 32'(be_cnt - be0), 32'd8);
    check("exits_low_cycles", 32'(low_cnt), 32'd48);
    check("entries_exits_idle", 32'(outs()), 32'(O_IDLE));

`ifdef STUCK_DET_EN
    fe0 = fe_cnt;
    bus.raw_front = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 21) check("stuck_before", 32'({bus.sens_front, bus.stuck_front}), 32'b00);
      if (k == 22) check("stuck_enter", 32'({bus.sens_front, bus.stuck_front}), 32'b11);
    end
    check("stuck_held", 32'(outs()), 32'b1100010);
    bus.raw_front = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) check("stuck_pending_clear", 32'(bus.stuck_front), 32'd1);
    end
    check("stuck_cleared", 32'(outs()), 32'(O_IDLE));
    check("stuck_one_strobe", 32'(fe_cnt - fe0), 32'd1);
    bus.raw_front = 1'b0;
    repeat (25) tick();
    check("fault_again", 32'(bus.stuck_front), 32'd1);
    rst = 1'b0;
    tick();
    check("fault_reset", 32'(outs()), 32'(O_IDLE));
    rst = 1'b1;
    bus.raw_front = 1'b1;
    repeat (8) tick();
    check("fault_reset_idle", 32'(outs()), 32'(O_IDLE));
`else
    bus.raw_front = 1'b0;
    repeat (30) tick();
    check("long_hold_active", 32'(outs()), 32'b0100000);
    bus.raw_front = 1'b1;
    repeat (8) tick();
    check("long_hold_release", 32'(outs()), 32'(O_IDLE));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
